// File: rtl/uart_wb_slave_pkg.sv
// Shared encodings and protocol bytes for the uart_wb bridge pair.
// Used by both uart_wb_slave and uart_wb_master.
package uart_wb_slave_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SEND_CMD,
        SEND_ADDR,
        SEND_DATA,
        WAIT_WACK,
        RECV_RDATA,
        DONE
    } state_t;

    localparam logic [7:0] CMD_WRITE = 8'h01;
    localparam logic [7:0] CMD_READ  = 8'h00;
    localparam logic [7:0] WRITE_ACK = 8'hAA;

    localparam int UART_CLKS_PER_BIT = 8;

    function automatic logic [7:0] byte_of(
        input logic [31:0] w,
        input logic [1:0]  i
    );
        return w[{i, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/uart_wb_slave_uart.sv
// 8N1 UART with a valid/ready byte port on each side.
// The receive side holds one byte; a byte arriving while it is full is discarded.
module uart_wb_slave_uart
    import uart_wb_slave_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       i_tx_valid,
    input  logic [7:0] i_tx_byte,
    output logic       o_tx_ready,
    output logic       o_serial_tx,
    input  logic       i_serial_rx,
    output logic       o_rx_valid,
    output logic [7:0] o_rx_byte,
    input  logic       i_rx_ready
);
    localparam logic [15:0] FULL = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] HALF = 16'(CLKS_PER_BIT / 2 - 1);

    logic [9:0]  r_tx_shift;
    logic [3:0]  r_tx_bits;
    logic [15:0] r_tx_baud;
    logic        r_tx_busy;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_tx_shift <= '1;
            r_tx_bits  <= '0;
            r_tx_baud  <= '0;
            r_tx_busy  <= 1'b0;
        end else if (!r_tx_busy) begin
            if (i_tx_valid) begin
                r_tx_shift <= {1'b1, i_tx_byte, 1'b0};
                r_tx_bits  <= '0;
                r_tx_baud  <= '0;
                r_tx_busy  <= 1'b1;
            end
        end else if (r_tx_baud == FULL) begin
            r_tx_baud  <= '0;
            r_tx_shift <= {1'b1, r_tx_shift[9:1]};
            if (r_tx_bits == 4'd9)
                r_tx_busy <= 1'b0;
            else
                r_tx_bits <= r_tx_bits + 4'd1;
        end else begin
            r_tx_baud <= r_tx_baud + 16'd1;
        end
    end

    assign o_tx_ready  = !r_tx_busy;
    assign o_serial_tx = r_tx_shift[0];

    logic        r_rx_s0;
    logic        r_rx_s1;
    logic        r_rx_busy;
    logic [15:0] r_rx_baud;
    logic [3:0]  r_rx_bits;
    logic [7:0]  r_rx_shift;
    logic        r_rx_valid;
    logic [7:0]  r_rx_data;
    logic [15:0] w_rx_target;
    logic        w_rx_free;

    assign w_rx_target = (r_rx_bits == 4'd0) ? HALF : FULL;
    assign w_rx_free   = !r_rx_valid || i_rx_ready;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_rx_s0    <= 1'b1;
            r_rx_s1    <= 1'b1;
            r_rx_busy  <= 1'b0;
            r_rx_baud  <= '0;
            r_rx_bits  <= '0;
            r_rx_shift <= '0;
            r_rx_valid <= 1'b0;
            r_rx_data  <= '0;
        end else begin
            r_rx_s0 <= i_serial_rx;
            r_rx_s1 <= r_rx_s0;
            if (r_rx_valid && i_rx_ready)
                r_rx_valid <= 1'b0;
            if (!r_rx_busy) begin
                if (!r_rx_s1) begin
                    r_rx_busy <= 1'b1;
                    r_rx_baud <= '0;
                    r_rx_bits <= '0;
                end
            end else if (r_rx_baud == w_rx_target) begin
                r_rx_baud <= '0;
                if (r_rx_bits == 4'd0) begin
                    // a start bit that is high again at mid-bit was a glitch
                    if (r_rx_s1)
                        r_rx_busy <= 1'b0;
                    else
                        r_rx_bits <= 4'd1;
                end else if (r_rx_bits == 4'd9) begin
                    r_rx_busy <= 1'b0;
                    if (r_rx_s1 && w_rx_free) begin
                        r_rx_valid <= 1'b1;
                        r_rx_data  <= r_rx_shift;
                    end
                end else begin
                    r_rx_shift <= {r_rx_s1, r_rx_shift[7:1]};
                    r_rx_bits  <= r_rx_bits + 4'd1;
                end
            end else begin
                r_rx_baud <= r_rx_baud + 16'd1;
            end
        end
    end

    assign o_rx_valid = r_rx_valid;
    assign o_rx_byte  = r_rx_data;

endmodule

// File: rtl/uart_wb_slave.sv
// Host end of the Wishbone-over-UART bridge: forwards Wishbone cycles serially.
// Define UART_WB_SLAVE_TIMEOUT_EN to add a per-byte response timeout.
module uart_wb_slave
    import uart_wb_slave_pkg::*;
#(
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd1000000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        serial_rx,
    output logic        serial_tx,
    input  logic [31:0] addr_in,
    input  logic [31:0] data_in,
    output logic [31:0] data_out,
    input  logic        cyc_in,
    input  logic        strobe_in,
    input  logic        we_in,
    output logic        ack_out,
    output logic        err_out
);
    state_t      r_state;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_rshift;
    logic [31:0] r_data;
    logic        r_we;
    logic        r_live;
    logic        r_ack;
    logic        r_err;
    logic        r_tx_valid;
    logic [7:0]  r_tx_byte;
    logic [1:0]  r_cnt;

    logic        w_tx_ready;
    logic        w_tx_fire;
    logic        w_rx_valid;
    logic        w_rx_ready;
    logic        w_rx_fire;
    logic [7:0]  w_rx_byte;
    logic        w_live;

    assign w_rx_ready = (r_state == WAIT_WACK) || (r_state == RECV_RDATA);
    assign w_tx_fire  = r_tx_valid && w_tx_ready;
    assign w_rx_fire  = w_rx_valid && w_rx_ready;
    assign w_live     = r_live && cyc_in;

`ifdef UART_WB_SLAVE_TIMEOUT_EN
    logic [31:0] r_tmo;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= IDLE;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_rshift   <= '0;
            r_data     <= '0;
            r_we       <= 1'b0;
            r_live     <= 1'b0;
            r_ack      <= 1'b0;
            r_err      <= 1'b0;
            r_tx_valid <= 1'b0;
            r_tx_byte  <= '0;
            r_cnt      <= '0;
`ifdef UART_WB_SLAVE_TIMEOUT_EN
            r_tmo      <= '0;
`endif
        end else begin
            r_ack <= 1'b0;
            r_err <= 1'b0;
            if (r_state != IDLE && !cyc_in)
                r_live <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (cyc_in && strobe_in) begin
                        r_addr     <= addr_in;
                        r_wdata    <= data_in;
                        r_we       <= we_in;
                        r_live     <= 1'b1;
                        r_state    <= SEND_CMD;
                        r_tx_valid <= 1'b1;
                        r_tx_byte  <= we_in ? CMD_WRITE : CMD_READ;
                    end
                end
                SEND_CMD: begin
                    if (w_tx_fire) begin
                        r_state   <= SEND_ADDR;
                        r_tx_byte <= byte_of(r_addr, 2'd0);
                    end
                end
                SEND_ADDR: begin
                    if (w_tx_fire) begin
                        r_cnt <= r_cnt + 2'd1;
                        if (r_cnt == 2'd3) begin
                            if (r_we) begin
                                r_state   <= SEND_DATA;
                                r_tx_byte <= byte_of(r_wdata, 2'd0);
                            end else begin
                                r_state    <= RECV_RDATA;
                                r_tx_valid <= 1'b0;
                            end
                        end else begin
                            r_tx_byte <= byte_of(r_addr, r_cnt + 2'd1);
                        end
                    end
                end
                SEND_DATA: begin
                    if (w_tx_fire) begin
                        r_cnt <= r_cnt + 2'd1;
                        if (r_cnt == 2'd3) begin
                            r_state    <= WAIT_WACK;
                            r_tx_valid <= 1'b0;
                        end else begin
                            r_tx_byte <= byte_of(r_wdata, r_cnt + 2'd1);
                        end
                    end
                end
                WAIT_WACK: begin
                    if (w_rx_fire) begin
                        r_state <= DONE;
                        r_ack   <= w_live && (w_rx_byte == WRITE_ACK);
                        r_err   <= w_live && (w_rx_byte != WRITE_ACK);
                    end
                end
                RECV_RDATA: begin
                    if (w_rx_fire) begin
                        r_cnt    <= r_cnt + 2'd1;
                        r_rshift <= {w_rx_byte, r_rshift[31:8]};
                        if (r_cnt == 2'd3) begin
                            r_state <= DONE;
                            r_ack   <= w_live;
                            if (w_live)
                                r_data <= {w_rx_byte, r_rshift[31:8]};
                        end
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_live  <= 1'b0;
                end
                default: r_state <= IDLE;
            endcase
`ifdef UART_WB_SLAVE_TIMEOUT_EN
            // restarts on every accepted byte; expiry overrides the case above
            if (!w_rx_ready || w_rx_fire) begin
                r_tmo <= '0;
            end else if (r_tmo == TIMEOUT_CYCLES - 32'd1) begin
                r_tmo   <= '0;
                r_cnt   <= '0;
                r_state <= DONE;
                r_err   <= w_live;
            end else begin
                r_tmo <= r_tmo + 32'd1;
            end
`endif
        end
    end

    assign ack_out  = r_ack;
    assign err_out  = r_err;
    assign data_out = r_data;

    uart_wb_slave_uart #(
        .CLKS_PER_BIT(UART_CLKS_PER_BIT)
    ) uart0 (
        .clock       (clock),
        .reset       (reset),
        .i_tx_valid  (r_tx_valid),
        .i_tx_byte   (r_tx_byte),
        .o_tx_ready  (w_tx_ready),
        .o_serial_tx (serial_tx),
        .i_serial_rx (serial_rx),
        .o_rx_valid  (w_rx_valid),
        .o_rx_byte   (w_rx_byte),
        .i_rx_ready  (w_rx_ready)
    );

endmodule

// File: tb/tb_uart_wb_slave.sv
// Directed bench for uart_wb_slave acting against a modelled remote master.
// Timeout sequence is included when UART_WB_SLAVE_TIMEOUT_EN is defined.
module tb_uart_wb_slave;
    import uart_wb_slave_pkg::*;

    localparam int CPB = UART_CLKS_PER_BIT;
    localparam int BIT = CPB * 10;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        serial_rx = 1'b1;
    logic        serial_tx;
    logic [31:0] addr_in = '0;
    logic [31:0] data_in = '0;
    logic [31:0] data_out;
    logic        cyc_in = 1'b0;
    logic        strobe_in = 1'b0;
    logic        we_in = 1'b0;
    logic        ack_out;
    logic        err_out;

    int n_checks = 0;
    int n_errs = 0;
    int ack_cnt = 0;
    int err_cnt = 0;
    logic [7:0] tx_q[$];

    always #5 clock = ~clock;

    uart_wb_slave #(
        .TIMEOUT_CYCLES(32'd100)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .serial_rx (serial_rx),
        .serial_tx (serial_tx),
        .addr_in   (addr_in),
        .data_in   (data_in),
        .data_out  (data_out),
        .cyc_in    (cyc_in),
        .strobe_in (strobe_in),
        .we_in     (we_in),
        .ack_out   (ack_out),
        .err_out   (err_out)
    );

    always @(negedge clock) begin
        if (ack_out) ack_cnt++;
        if (err_out) err_cnt++;
    end

    // remote receiver: decode serial_tx frames into tx_q
    initial begin
        logic [7:0] b;
        forever begin
            @(negedge serial_tx);
            #(BIT / 2);
            for (int k = 0; k < 8; k++) begin
                #(BIT);
                b[k] = serial_tx;
            end
            #(BIT);
            tx_q.push_back(b);
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        string       name;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          n_tx;
        logic [71:0] tx;
        int          n_rsp;
        logic [31:0] rsp;
        int          acks;
        int          errs;
        logic [31:0] dout;
    } vec_t;

    vec_t vecs[4];

    task automatic check(input string name, input logic [71:0] act,
                         input logic [71:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic bound_fail(input string name);
        n_checks++;
        n_errs++;
        $display("FAIL %s: wait bound expired", name);
    endtask

    task automatic send_byte(input logic [7:0] b);
        serial_rx = 1'b0;
        #(BIT);
        for (int k = 0; k < 8; k++) begin
            serial_rx = b[k];
            #(BIT);
        end
        serial_rx = 1'b1;
        #(BIT);
    endtask

    task automatic start_req(input logic we, input logic [31:0] a,
                             input logic [31:0] d);
        @(negedge clock);
        cyc_in = 1'b1;
        strobe_in = 1'b1;
        we_in = we;
        addr_in = a;
        data_in = d;
    endtask

    task automatic wait_rx_ready(input string name);
        int n = 0;
        while (!dut.w_rx_ready && n < 3000) begin
            @(negedge clock);
            n++;
        end
        if (!dut.w_rx_ready) bound_fail({name, "_rx_ready"});
    endtask

    task automatic wait_end(input string name);
        int n = 0;
        while (!(ack_out || err_out) && n < 2000) begin
            @(negedge clock);
            n++;
        end
        if (!(ack_out || err_out)) bound_fail({name, "_end"});
        cyc_in = 1'b0;
        strobe_in = 1'b0;
    endtask

    task automatic wait_tx(input string name, input int n_tx);
        int n = 0;
        while (tx_q.size() < n_tx && n < 3000) begin
            @(negedge clock);
            n++;
        end
        if (tx_q.size() < n_tx) bound_fail({name, "_tx_wait"});
    endtask

    task automatic check_tx(input string name, input int n_tx,
                            input logic [71:0] tx);
        check({name, "_tx_count"}, 72'(tx_q.size()), 72'(n_tx));
        for (int i = 0; i < n_tx && i < tx_q.size(); i++)
            check($sformatf("%s_tx%0d", name, i), 72'(tx_q[i]),
                  72'(tx[i*8 +: 8]));
    endtask

    task automatic run_vec(input vec_t v);
        tx_q.delete();
        ack_cnt = 0;
        err_cnt = 0;
        start_req(v.we, v.addr, v.wdata);
        wait_rx_ready(v.name);
        for (int i = 0; i < v.n_rsp; i++)
            send_byte(v.rsp[i*8 +: 8]);
        wait_end(v.name);
        repeat (3) @(negedge clock);
        wait_tx(v.name, v.n_tx);
        check_tx(v.name, v.n_tx, v.tx);
        check({v.name, "_acks"}, 72'(ack_cnt), 72'(v.acks));
        check({v.name, "_errs"}, 72'(err_cnt), 72'(v.errs));
        check({v.name, "_data_out"}, 72'(data_out), 72'(v.dout));
        check({v.name, "_idle"}, 72'(dut.r_state == IDLE), 72'(1));
    endtask

    initial begin
        vecs[0] = '{"wr_ok", 1'b1, 32'h10203040, 32'hCAFEBABE,
                    9, 72'hCAFEBABE_10203040_01,
                    1, 32'h000000AA, 1, 0, 32'h00000000};
        vecs[1] = '{"rd_ok", 1'b0, 32'h00000004, 32'h0,
                    5, 72'h00000004_00,
                    4, 32'h12345678, 1, 0, 32'h12345678};
        vecs[2] = '{"wr_bad_ack", 1'b1, 32'h00000008, 32'h11223344,
                    9, 72'h11223344_00000008_01,
                    1, 32'h00000055, 0, 1, 32'h12345678};
        vecs[3] = '{"rd_ok2", 1'b0, 32'h89ABCDEF, 32'h0,
                    5, 72'h89ABCDEF_00,
                    4, 32'hDEADBEEF, 1, 0, 32'hDEADBEEF};

        repeat (3) @(negedge clock);
        check("rst_ack", 72'(ack_out), 72'(0));
        check("rst_err", 72'(err_out), 72'(0));
        check("rst_data_out", 72'(data_out), 72'(0));
        check("rst_serial_tx", 72'(serial_tx), 72'(1));
        reset = 1'b0;
        repeat (2) @(negedge clock);

        for (int i = 0; i < 4; i++)
            run_vec(vecs[i]);

        // cyc_in dropped mid-address: exchange still completes silently
        tx_q.delete();
        ack_cnt = 0;
        err_cnt = 0;
        start_req(1'b1, 32'h10203040, 32'hCAFEBABE);
        wait_tx("drop", 3);
        @(negedge clock);
        cyc_in = 1'b0;
        strobe_in = 1'b0;
        wait_rx_ready("drop");
        send_byte(8'hAA);
        begin
            int n = 0;
            while (dut.r_state != IDLE && n < 500) begin
                @(negedge clock);
                n++;
            end
        end
        repeat (5) @(negedge clock);
        wait_tx("drop", 9);
        check_tx("drop", 9, 72'hCAFEBABE_10203040_01);
        check("drop_acks", 72'(ack_cnt), 72'(0));
        check("drop_errs", 72'(err_cnt), 72'(0));
        check("drop_rx_consumed", 72'(dut.uart0.o_rx_valid), 72'(0));
        check("drop_idle", 72'(dut.r_state == IDLE), 72'(1));
        check("drop_data_out", 72'(data_out), 72'(32'hDEADBEEF));

        // reset while the data bytes are going out
        ack_cnt = 0;
        err_cnt = 0;
        start_req(1'b1, 32'h10203040, 32'hCAFEBABE);
        begin
            int n = 0;
            while (dut.r_state != SEND_DATA && n < 3000) begin
                @(negedge clock);
                n++;
            end
            if (dut.r_state != SEND_DATA) bound_fail("rst_mid_send_data");
        end
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("rst_mid_idle", 72'(dut.r_state == IDLE), 72'(1));
        check("rst_mid_ack", 72'(ack_out), 72'(0));
        check("rst_mid_err", 72'(err_out), 72'(0));
        check("rst_mid_data_out", 72'(data_out), 72'(0));
        check("rst_mid_tx_valid", 72'(dut.r_tx_valid), 72'(0));
        check("rst_mid_serial_tx", 72'(serial_tx), 72'(1));
        reset = 1'b0;
        cyc_in = 1'b0;
        strobe_in = 1'b0;
        repeat (30 * CPB) @(negedge clock);
        check("rst_mid_no_pulse", 72'(ack_cnt + err_cnt), 72'(0));
        vecs[1].name = "post_rst_rd";
        run_vec(vecs[1]);

`ifdef UART_WB_SLAVE_TIMEOUT_EN
        // remote stops after two read bytes
        ack_cnt = 0;
        err_cnt = 0;
        start_req(1'b0, 32'h00000040, 32'h0);
        wait_rx_ready("tmo");
        send_byte(8'h11);
        send_byte(8'h22);
        begin
            int n = 0;
            while (!(ack_out || err_out) && n < 400) begin
                @(negedge clock);
                n++;
            end
            if (!(ack_out || err_out)) bound_fail("tmo_end");
            check("tmo_latency", 72'(n >= 40 && n <= 130), 72'(1));
        end
        cyc_in = 1'b0;
        strobe_in = 1'b0;
        repeat (3) @(negedge clock);
        check("tmo_errs", 72'(err_cnt), 72'(1));
        check("tmo_acks", 72'(ack_cnt), 72'(0));
        check("tmo_data_out", 72'(data_out), 72'(32'h12345678));
        check("tmo_idle", 72'(dut.r_state == IDLE), 72'(1));
`endif

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errs);
        $finish;
    end

endmodule
